// File: rtl/cdb_pkg.sv
// Shared CDB broadcast types used by the arbiter, RS, phy regfile and ROB.
package cdb_pkg;

  localparam int CDB_DATA_W = 32;
  localparam int CDB_PREG_W = 6;
  localparam int CDB_TAG_W  = 6;

  typedef struct packed {
    logic [CDB_DATA_W-1:0] data;
    logic [CDB_PREG_W-1:0] phy_reg;
    logic [CDB_TAG_W-1:0]  tag;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO; clear empties it and overrides push/pop.
module cdb_req_fifo
  import cdb_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  cdb_entry_t    din,
  output logic [CW-1:0] count,
  output cdb_entry_t    head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  cdb_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (push && !clear)
      mem[wr_ptr] <= din;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: per-requester FIFOs feeding NUM_CDB
// registered broadcast lanes.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_CDB    = 1,
  parameter int DATA_W     = CDB_DATA_W,
  parameter int PREG_W     = CDB_PREG_W,
  parameter int TAG_W      = CDB_TAG_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*PREG_W-1:0] req_phy_reg,
  input  logic [NUM_REQ*TAG_W-1:0]  req_tag,
  output logic [NUM_CDB-1:0]        cdb_valid,
  output logic [NUM_CDB*DATA_W-1:0] cdb_data,
  output logic [NUM_CDB*PREG_W-1:0] cdb_phy_reg,
  output logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
  output logic [15:0]               conflict_cnt
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = IW + 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [CW-1:0]      count [NUM_REQ];
  cdb_entry_t         head  [NUM_REQ];
  logic [NUM_REQ-1:0] nonempty;
  logic [NUM_REQ-1:0] push;
  logic [NUM_REQ-1:0] pop;
  logic [IW-1:0]      rr_ptr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_fifo
    cdb_entry_t din;

    assign din.data    = req_data[i*DATA_W +: DATA_W];
    assign din.phy_reg = req_phy_reg[i*PREG_W +: PREG_W];
    assign din.tag     = req_tag[i*TAG_W +: TAG_W];

    assign req_ready[i] = count[i] != CW'(FIFO_DEPTH);
    assign nonempty[i]  = count[i] != '0;
    assign push[i]      = req_valid[i] & req_ready[i] & ~flush;

    cdb_req_fifo #(
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .push  (push[i]),
      .pop   (pop[i]),
      .din   (din),
      .count (count[i]),
      .head  (head[i])
    );
  end

  logic [NUM_CDB-1:0] lane_vld;
  logic [IW-1:0]      lane_sel [NUM_CDB];
  logic [IW-1:0]      last_idx;
  logic [IW-1:0]      next_ptr;
  logic [SW-1:0]      scan_sum;
  logic [IW-1:0]      scan_idx;
  int                 n_grant;

  // Walk requesters from rr_ptr; the k-th hit lands on lane k.
  always_comb begin
    pop      = '0;
    lane_vld = '0;
    last_idx = rr_ptr;
    n_grant  = 0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NUM_CDB; k++)
      lane_sel[k] = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      scan_sum = {1'b0, rr_ptr} + SW'(j);
      if (scan_sum >= SW'(NUM_REQ))
        scan_sum = scan_sum - SW'(NUM_REQ);
      scan_idx = scan_sum[IW-1:0];
      if (!flush && nonempty[scan_idx] && n_grant < NUM_CDB) begin
        for (int k = 0; k < NUM_CDB; k++) begin
          if (k == n_grant) begin
            lane_vld[k] = 1'b1;
            lane_sel[k] = scan_idx;
          end
        end
        pop[scan_idx] = 1'b1;
        last_idx      = scan_idx;
        n_grant       = n_grant + 1;
      end
    end
  end

  assign next_ptr = (last_idx == IW'(NUM_REQ - 1)) ? '0
                                                   : last_idx + IW'(1);

  cdb_entry_t lane_q [NUM_CDB];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr       <= '0;
      cdb_valid    <= '0;
      conflict_cnt <= '0;
      for (int k = 0; k < NUM_CDB; k++)
        lane_q[k] <= '0;
    end else begin
      cdb_valid <= lane_vld;
      for (int k = 0; k < NUM_CDB; k++) begin
        if (lane_vld[k])
          lane_q[k] <= head[lane_sel[k]];
      end
      if (lane_vld[0])
        rr_ptr <= next_ptr;
      if (!flush && $countones(nonempty) > NUM_CDB &&
          conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  for (genvar k = 0; k < NUM_CDB; k++) begin : g_lane
    assign cdb_data[k*DATA_W +: DATA_W]    = lane_q[k].data;
    assign cdb_phy_reg[k*PREG_W +: PREG_W] = lane_q[k].phy_reg;
    assign cdb_tag[k*TAG_W +: TAG_W]       = lane_q[k].tag;
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: queue-based reference model for a 1-lane and
// a 2-lane instance driven by the same requesters.
module tb_cdb_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [23:0]  req_phy_reg = '0;
  logic [23:0]  req_tag = '0;

  logic [3:0]  ready0, ready1;
  logic        v0;
  logic [1:0]  v1;
  logic [31:0] d0;
  logic [63:0] d1;
  logic [5:0]  p0, t0;
  logic [11:0] p1, t1;
  logic [15:0] c0, c1;

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(1)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(ready0),
    .req_data(req_data), .req_phy_reg(req_phy_reg), .req_tag(req_tag),
    .cdb_valid(v0), .cdb_data(d0), .cdb_phy_reg(p0), .cdb_tag(t0),
    .conflict_cnt(c0)
  );

  cdb_arbiter #(.NUM_REQ(4), .NUM_CDB(2)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(ready1),
    .req_data(req_data), .req_phy_reg(req_phy_reg), .req_tag(req_tag),
    .cdb_valid(v1), .cdb_data(d1), .cdb_phy_reg(p1), .cdb_tag(t1),
    .conflict_cnt(c1)
  );

  logic [3:0]  rdy [2];
  logic [1:0]  val [2];
  logic [43:0] pay [2][2];
  logic [15:0] cnf [2];

  assign rdy[0] = ready0;
  assign rdy[1] = ready1;
  assign val[0] = {1'b0, v0};
  assign val[1] = v1;
  assign pay[0][0] = {d0, p0, t0};
  assign pay[0][1] = '0;
  assign pay[1][0] = {d1[31:0], p1[5:0], t1[5:0]};
  assign pay[1][1] = {d1[63:32], p1[11:6], t1[11:6]};
  assign cnf[0] = c0;
  assign cnf[1] = c1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: one queue per requester, depth 2.
  logic [43:0] mq [8][$];
  int          mrr [2];
  logic [1:0]  ev [2];
  logic [43:0] epay [2][2];
  logic [15:0] mconf [2];

  function automatic logic [43:0] ent(input int r);
    return {req_data[r*32 +: 32], req_phy_reg[r*6 +: 6], req_tag[r*6 +: 6]};
  endfunction

  task automatic model_reset(input int n);
    for (int r = 0; r < 4; r++) mq[n*4+r].delete();
    mrr[n] = 0;
    ev[n] = '0;
    epay[n][0] = '0;
    epay[n][1] = '0;
    mconf[n] = '0;
  endtask

  task automatic model_step(input int n, input int nc);
    int sz [4];
    int ne, g, last, r;
    for (int i = 0; i < 4; i++) sz[i] = mq[n*4+i].size();
    if (flush) begin
      for (int i = 0; i < 4; i++) mq[n*4+i].delete();
      ev[n] = '0;
    end else begin
      ne = 0;
      for (int i = 0; i < 4; i++) if (sz[i] > 0) ne++;
      if (ne > nc && mconf[n] != 16'hFFFF) mconf[n] = mconf[n] + 16'd1;
      g = 0;
      last = 0;
      for (int j = 0; j < 4; j++) begin
        r = (mrr[n] + j) % 4;
        if (sz[r] > 0 && g < nc) begin
          epay[n][g] = mq[n*4+r].pop_front();
          g++;
          last = r;
        end
      end
      for (int k = 0; k < 2; k++) ev[n][k] = (k < g);
      if (g > 0) mrr[n] = (last + 1) % 4;
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && sz[i] < 2) mq[n*4+i].push_back(ent(i));
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 1);
      model_step(1, 2);
    end
  end

  always @(negedge clk) begin
    logic [3:0] er;
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        for (int r = 0; r < 4; r++) er[r] = mq[n*4+r].size() < 2;
        chk($sformatf("ready%0d", n), rdy[n], er);
        chk($sformatf("valid%0d", n), val[n], ev[n]);
        for (int k = 0; k <= n; k++)
          chk($sformatf("payload%0d_lane%0d", n, k), pay[n][k], epay[n][k]);
        chk($sformatf("conflict%0d", n), cnf[n], mconf[n]);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    req_valid = '0;
    flush = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic rand_inputs();
    for (int r = 0; r < 4; r++) begin
      req_valid[r] = ($urandom % 100) < 60;
      req_data[r*32 +: 32] = $urandom;
      req_phy_reg[r*6 +: 6] = 6'($urandom);
      req_tag[r*6 +: 6] = 6'($urandom);
    end
    flush = ($urandom % 25) == 0;
  endtask

  logic [5:0] seen [4];
  int ntag;

  initial begin
    model_reset(0);
    model_reset(1);

    // Reset state
    step();
    step();
    chk("rst_valid0", v0, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_conflict0", c0, 0);
    reset = 1'b1;
    step();
    chk_en = 1'b1;
    chk("rst_ready0", ready0, 4'hF);
    chk("rst_ready1", ready1, 4'hF);
    chk("rst_payload0", {d0, p0, t0}, 0);

    // Single requester latency
    req_valid = 4'b0100;
    req_data[64 +: 32] = 32'h11;
    req_tag[12 +: 6] = 6'd3;
    req_phy_reg[12 +: 6] = 6'd9;
    step();
    req_valid = '0;
    chk("single_not_early", v0, 0);
    step();
    chk("single_valid", v0, 1);
    chk("single_data", d0, 32'h11);
    chk("single_tag", t0, 6'd3);
    chk("single_lane2", v1, 2'b01);
    step();
    chk("single_one_cycle", v0, 0);

    // All four push for 8 cycles
    pulse_reset();
    ntag = 0;
    for (int c = 0; c < 20; c++) begin
      if (c < 8) begin
        req_valid = 4'hF;
        for (int r = 0; r < 4; r++) begin
          req_data[r*32 +: 32] = 32'(c * 16 + r);
          req_tag[r*6 +: 6] = 6'(r);
          req_phy_reg[r*6 +: 6] = 6'(c);
        end
      end else begin
        req_valid = '0;
      end
      step();
      if (v0 && ntag < 4) begin
        seen[ntag] = t0;
        ntag++;
      end
      if (c == 1) begin
        chk("ready_full", ready0, 4'b0001);
        chk("conflict_first", c0, 16'd1);
      end
    end
    chk("grant_cnt", ntag, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant_order%0d", i), seen[i], 6'(i));

    // Two-lane wraparound
    pulse_reset();
    for (int r = 0; r < 4; r++) begin
      req_tag[r*6 +: 6] = 6'(r);
      req_data[r*32 +: 32] = 32'hA0 + 32'(r);
    end
    req_valid = 4'b0110;
    step();
    req_valid = 4'b1001;
    step();
    chk("lanes_a", {v1, t1}, {2'b11, 6'd2, 6'd1});
    req_valid = 4'b0011;
    step();
    chk("lanes_wrap", {v1, t1}, {2'b11, 6'd0, 6'd3});
    chk("lanes_wrap_data", d1, {32'hA0, 32'hA3});
    req_valid = '0;
    step();
    chk("lanes_rr1", {v1, t1}, {2'b11, 6'd0, 6'd1});

    // Flush with pending entries and a concurrent push
    pulse_reset();
    req_valid = 4'b1101;
    step();
    flush = 1'b1;
    req_valid = 4'b0010;
    req_data[32 +: 32] = 32'hDEAD;
    step();
    flush = 1'b0;
    req_valid = '0;
    chk("flush_valid0", v0, 0);
    chk("flush_valid1", v1, 0);
    chk("flush_ready0", ready0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("flush_quiet", {v1, v0}, 0);
    end

    // Random traffic with an asynchronous reset in the middle
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      if (i == 1500) begin
        reset = 1'b0;
        #1;
        chk("async_valid0", v0, 0);
        chk("async_valid1", v1, 0);
        chk("async_conflict0", c0, 0);
        chk("async_conflict1", c1, 0);
        step();
        reset = 1'b1;
      end
      step();
    end

    // Conflict counter saturation
    pulse_reset();
    req_valid = 4'hF;
    for (int i = 0; i < 65540; i++) step();
    chk("sat_conflict", c0, 16'hFFFF);
    for (int i = 0; i < 4; i++) step();
    chk("sat_hold", c0, 16'hFFFF);
    req_valid = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
